uart_bus_initiator: RTL

//  Bus initiator for the memory-mapped UART peripheral (read/write/address/data, *_response handshake).

---
 rtl/uart_bus_initiator.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/uart_bus_initiator.sv
// Bus initiator for the memory-mapped UART: pulls received words into a valid/ready
// command stream and writes response-stream words back to the peripheral for transmission.
module uart_bus_initiator #(
    parameter logic [31:0] UART_ADDR      = 32'h0000_0000,
    parameter int          WORD_BYTES     = 1,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx_empty,
    output logic        read,
    output logic        write,
    output logic [31:0] address,
    output logic [31:0] write_data,
    input  logic        read_response,
    input  logic        write_response,
    input  logic [31:0] read_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [31:0] cmd_data,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [31:0] rsp_data,
    output logic        bus_timeout,
    output logic [15:0] rx_words,
    output logic [15:0] tx_words
);

    localparam int          SHIFT     = 8 * (4 - WORD_BYTES);
    localparam logic [31:0] DATA_MASK = 32'hFFFF_FFFF >> SHIFT;
    localparam int          TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam bit          TMO_EN    = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        RD_HOLD = 3'd3,
        WR_REQ  = 3'd4,
        WR_WAIT = 3'd5,
        WR_HOLD = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic          read_q, read_d;
    logic          write_q, write_d;
    logic [31:0]   write_data_q, write_data_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [31:0]   cmd_data_q, cmd_data_d;
    logic          bus_timeout_q, bus_timeout_d;
    logic [15:0]   rx_words_q, rx_words_d;
    logic [15:0]   tx_words_q, tx_words_d;
    logic          last_wr_q, last_wr_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          rd_ok;
    logic          take_wr;
    logic          waiting;

    // Next-state, bus request and command/counter logic
    always_comb begin
        state_d       = state_q;
        write_data_d  = write_data_q;
        cmd_data_d    = cmd_data_q;
        bus_timeout_d = bus_timeout_q;
        rx_words_d    = rx_words_q;
        tx_words_d    = tx_words_q;
        last_wr_d     = last_wr_q;
        tmo_cnt_d     = tmo_cnt_q;
        take_wr       = 1'b0;
        waiting       = 1'b0;
        rd_ok         = !uart_rx_empty && !cmd_valid_q;

        // The command channel drains independently of the bus FSM.
        if (cmd_valid_q && cmd_ready) begin
            cmd_valid_d = 1'b0;
        end else begin
            cmd_valid_d = cmd_valid_q;
        end

        case (state_q)
            IDLE: begin
                if (rsp_valid && (!rd_ok || !last_wr_q)) begin
                    take_wr      = 1'b1;
                    last_wr_d    = 1'b1;
                    write_data_d = rsp_data << SHIFT;
                    state_d      = WR_REQ;
                end else if (rd_ok) begin
                    last_wr_d = 1'b0;
                    state_d   = RD_REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                tmo_cnt_d = {TW{1'b0}};
                state_d   = RD_WAIT;
            end
            RD_WAIT: begin
                if (read_response) begin
                    cmd_data_d  = read_data & DATA_MASK;
                    cmd_valid_d = 1'b1;
                    rx_words_d  = rx_words_q + 16'd1;
                    state_d     = RD_HOLD;
                end else begin
                    waiting = 1'b1;
                end
            end
            WR_REQ: begin
                tmo_cnt_d = {TW{1'b0}};
                state_d   = WR_WAIT;
            end
            WR_WAIT: begin
                if (write_response) begin
                    tx_words_d = tx_words_q + 16'd1;
                    state_d    = WR_HOLD;
                end else begin
                    waiting = 1'b1;
                end
            end
            RD_HOLD: state_d = IDLE;
            WR_HOLD: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Counter saturates at the limit; the flag is sticky and the FSM keeps waiting.
        if (waiting) begin
            if (tmo_cnt_q != TMO_LIMIT) begin
                tmo_cnt_d = tmo_cnt_q + {{(TW-1){1'b0}}, 1'b1};
            end else begin
                tmo_cnt_d = tmo_cnt_q;
            end
            if (TMO_EN && (tmo_cnt_d == TMO_LIMIT)) begin
                bus_timeout_d = 1'b1;
            end else begin
                bus_timeout_d = bus_timeout_q;
            end
        end else begin
            waiting = 1'b0;
        end

        read_d  = (state_d == RD_REQ);
        write_d = (state_d == WR_REQ);
    end

    // Accept strobe coincides with the IDLE decision that consumes rsp_data
    always_comb begin
        rsp_ready = 1'b0;
        if (take_wr && !reset) begin
            rsp_ready = 1'b1;
        end else begin
            rsp_ready = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            write_data_q  <= 32'h0000_0000;
            cmd_valid_q   <= 1'b0;
            cmd_data_q    <= 32'h0000_0000;
            bus_timeout_q <= 1'b0;
            rx_words_q    <= 16'h0000;
            tx_words_q    <= 16'h0000;
            last_wr_q     <= 1'b0;
            tmo_cnt_q     <= {TW{1'b0}};
        end else begin
            state_q       <= state_d;
            read_q        <= read_d;
            write_q       <= write_d;
            write_data_q  <= write_data_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_data_q    <= cmd_data_d;
            bus_timeout_q <= bus_timeout_d;
            rx_words_q    <= rx_words_d;
            tx_words_q    <= tx_words_d;
            last_wr_q     <= last_wr_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign address     = UART_ADDR;
    assign read        = read_q;
    assign write       = write_q;
    assign write_data  = write_data_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_data    = cmd_data_q;
    assign bus_timeout = bus_timeout_q;
    assign rx_words    = rx_words_q;
    assign tx_words    = tx_words_q;

endmodule
